qrd_stream_ctrl: RTL

//  Sequencer that wraps the 4x4 complex QRD core (QRD), driven by a streaming interface.
//  - Accepts one H matrix element-serially.
//  - Generates the skewed, identity-augmented row feed and row flags the core expects.
//  - Collects the skewed R/QH row outputs.
//  - Re-streams R then QH row-major, with backpressure.

---
 rtl/qrd_pkg.sv | 44 ++++
 rtl/qrd_out_buf.sv | 52 +++++
 rtl/qrd_stream_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/qrd_pkg.sv
// Shared constants, FSM encoding and the skew/identity feed rule for the QRD stream sequencer.
package qrd_pkg;

  localparam int W      = 14;
  localparam int ONE    = 1024;
  localparam int N      = 4;
  localparam int WDOG   = 1000;
  localparam int STEPS  = 16;
  localparam int BEATS  = 2 * N * N;
  localparam int IDX_W  = 4;
  localparam int STEP_W = 4;
  localparam int BEAT_W = 5;
  localparam int WDOG_W = $clog2(WDOG);
  localparam int R_LAT  = 5;
  localparam int QH_LAT = 9;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_e;

  typedef struct packed {
    logic       use_h;
    logic       is_one;
    logic [1:0] col;
  } feed_sel_t;

  // Row k at step l sees H[k][c] for c=l-k in 0..3, then one identity row, then zeros.
  function automatic feed_sel_t feed_elem(input int k, input int l);
    feed_sel_t s;
    int        c;
    s = '0;
    c = l - k;
    if (c >= 0 && c < N) begin
      s.use_h = 1'b1;
      s.col   = 2'(c);
    end else if (c >= N && c < 2 * N) begin
      s.is_one = (c - N == k);
    end
    return s;
  endfunction

endpackage

// File: rtl/qrd_out_buf.sv
// Capture buffer for the skewed R/QH core outputs: 32 complex slots, per-slot valid,
// one write port per core row and a single read port that returns 0 for unfilled slots.
module qrd_out_buf
  import qrd_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic [N-1:0]             wen_i,
  input  logic [N-1:0][BEAT_W-1:0] waddr_i,
  input  logic [N-1:0][W-1:0]      wdata_r_i,
  input  logic [N-1:0][W-1:0]      wdata_i_i,
  input  logic [BEAT_W-1:0]        raddr_i,
  output logic [W-1:0]             rdata_r_o,
  output logic [W-1:0]             rdata_i_o,
  output logic                     full_o
);

  logic [W-1:0]     mem_r_q [BEATS];
  logic [W-1:0]     mem_i_q [BEATS];
  logic [BEATS-1:0] vld_q;
  logic [BEATS-1:0] vld_d;
  logic [BEATS-1:0] wmask;

  always_comb begin
    wmask = '0;
    for (int k = 0; k < N; k++) begin
      if (wen_i[k]) wmask[waddr_i[k]] = 1'b1;
    end
    vld_d = clr_i ? '0 : (vld_q | wmask);
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < N; k++) begin
      if (wen_i[k]) begin
        mem_r_q[waddr_i[k]] <= wdata_r_i[k];
        mem_i_q[waddr_i[k]] <= wdata_i_i[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vld_q <= '0;
    else         vld_q <= vld_d;
  end

  // Includes same-cycle writes so the final step's captures count toward completeness.
  assign full_o    = &(vld_q | wmask);
  assign rdata_r_o = vld_q[raddr_i] ? mem_r_q[raddr_i] : '0;
  assign rdata_i_o = vld_q[raddr_i] ? mem_i_q[raddr_i] : '0;

endmodule

// File: rtl/qrd_stream_ctrl.sv
// Streaming sequencer around the 4x4 complex QRD core: loads H element-serially, feeds the
// skewed identity-augmented rows, captures R/QH and re-streams them with backpressure.
module qrd_stream_ctrl
  import qrd_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [W-1:0] s_data_r,
  input  logic signed [W-1:0] s_data_i,
  output logic signed [W-1:0] row_in_1_r,
  output logic signed [W-1:0] row_in_1_i,
  output logic signed [W-1:0] row_in_2_r,
  output logic signed [W-1:0] row_in_2_i,
  output logic signed [W-1:0] row_in_3_r,
  output logic signed [W-1:0] row_in_3_i,
  output logic signed [W-1:0] row_in_4_r,
  output logic signed [W-1:0] row_in_4_i,
  output logic                row_in_1_f,
  output logic                row_in_2_f,
  output logic                row_in_3_f,
  input  logic                core_in_ready,
  input  logic                core_out_valid,
  input  logic signed [W-1:0] row_out_1_r,
  input  logic signed [W-1:0] row_out_1_i,
  input  logic signed [W-1:0] row_out_2_r,
  input  logic signed [W-1:0] row_out_2_i,
  input  logic signed [W-1:0] row_out_3_r,
  input  logic signed [W-1:0] row_out_3_i,
  input  logic signed [W-1:0] row_out_4_r,
  input  logic signed [W-1:0] row_out_4_i,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [W-1:0] m_data_r,
  output logic signed [W-1:0] m_data_i,
  output logic                m_is_qh,
  output logic                m_last,
  output logic                busy,
  output logic                err_wdog,
  output logic                err_miss
);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q;
  logic [STEP_W-1:0]        step_q;
  logic [BEAT_W-1:0]        beat_q;
  logic [WDOG_W-1:0]        wdog_q;
  logic                     err_wdog_q, err_miss_q;
  logic [W-1:0]             h_r_q [N*N];
  logic [W-1:0]             h_i_q [N*N];
  logic [N-1:0][W-1:0]      row_r_q, row_i_q, feed_r_d, feed_i_d;
  logic [2:0]               flag_q, flag_d;
  logic [N-1:0]             cap_wen;
  logic [N-1:0][BEAT_W-1:0] cap_addr;
  logic [N-1:0][W-1:0]      out_r, out_i;
  logic [W-1:0]             rd_r, rd_i;
  logic                     buf_full, buf_clr;
  logic                     s_fire, step_fire, run_done, wdog_hit, m_fire;

  assign s_ready   = (state_q == LOAD);
  assign busy      = (state_q != LOAD);
  assign m_valid   = (state_q == OUT);
  assign s_fire    = s_valid && s_ready;
  assign step_fire = (state_q == RUN) && core_in_ready;
  assign run_done  = step_fire && (step_q == STEP_W'(STEPS - 1));
  assign wdog_hit  = (state_q == RUN) && !core_in_ready && (wdog_q == WDOG_W'(WDOG - 1));
  assign m_fire    = m_valid && m_ready;
  assign buf_clr   = s_fire && (idx_q == IDX_W'(N * N - 1));

  always_ff @(posedge clk) begin
    if (s_fire) begin
      h_r_q[idx_q] <= s_data_r;
      h_i_q[idx_q] <= s_data_i;
    end
  end

  always_comb begin
    feed_sel_t  sel;
    logic [3:0] hidx;
    for (int k = 0; k < N; k++) begin
      sel         = feed_elem(k, int'(step_q));
      hidx        = {2'(k), sel.col};
      feed_r_d[k] = '0;
      feed_i_d[k] = '0;
      if (sel.use_h) begin
        feed_r_d[k] = h_r_q[hidx];
        feed_i_d[k] = h_i_q[hidx];
      end else if (sel.is_one) begin
        feed_r_d[k] = W'(ONE);
      end
    end
    flag_d = {step_q == STEP_W'(4), step_q == STEP_W'(2), step_q == STEP_W'(0)};
  end

  // Core row k emits R[k][*] at steps 5+k..8+k and QH[k][*] at steps 9+k..12+k.
  always_comb begin
    int st;
    st = int'(step_q);
    for (int k = 0; k < N; k++) begin
      cap_wen[k]  = 1'b0;
      cap_addr[k] = '0;
      if (step_fire && core_out_valid) begin
        if (st >= R_LAT + k && st <= R_LAT + N - 1 + k) begin
          cap_wen[k]  = 1'b1;
          cap_addr[k] = {1'b0, 2'(k), 2'(st - R_LAT - k)};
        end else if (st >= QH_LAT + k && st <= QH_LAT + N - 1 + k) begin
          cap_wen[k]  = 1'b1;
          cap_addr[k] = {1'b1, 2'(k), 2'(st - QH_LAT - k)};
        end
      end
    end
  end

  assign out_r = {row_out_4_r, row_out_3_r, row_out_2_r, row_out_1_r};
  assign out_i = {row_out_4_i, row_out_3_i, row_out_2_i, row_out_1_i};

  qrd_out_buf u_out_buf (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (buf_clr),
    .wen_i     (cap_wen),
    .waddr_i   (cap_addr),
    .wdata_r_i (out_r),
    .wdata_i_i (out_i),
    .raddr_i   (beat_q),
    .rdata_r_o (rd_r),
    .rdata_i_o (rd_i),
    .full_o    (buf_full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (buf_clr) state_d = RUN;
      RUN:     if (run_done) state_d = OUT;
               else if (wdog_hit) state_d = LOAD;
      OUT:     if (m_fire && beat_q == BEAT_W'(BEATS - 1)) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      idx_q      <= '0;
      step_q     <= '0;
      beat_q     <= '0;
      wdog_q     <= '0;
      err_wdog_q <= 1'b0;
      err_miss_q <= 1'b0;
      row_r_q    <= '0;
      row_i_q    <= '0;
      flag_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        LOAD: begin
          step_q <= '0;
          wdog_q <= '0;
          if (s_fire) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == '0) begin
              err_wdog_q <= 1'b0;
              err_miss_q <= 1'b0;
            end
          end
        end
        RUN: begin
          beat_q <= '0;
          if (core_in_ready) begin
            wdog_q  <= '0;
            row_r_q <= feed_r_d;
            row_i_q <= feed_i_d;
            flag_q  <= flag_d;
            step_q  <= step_q + 1'b1;
            if (run_done) err_miss_q <= err_miss_q | ~buf_full;
          end else if (wdog_hit) begin
            err_wdog_q <= 1'b1;
            row_r_q    <= '0;
            row_i_q    <= '0;
            flag_q     <= '0;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        OUT: if (m_fire) beat_q <= beat_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign row_in_1_r = row_r_q[0];
  assign row_in_1_i = row_i_q[0];
  assign row_in_2_r = row_r_q[1];
  assign row_in_2_i = row_i_q[1];
  assign row_in_3_r = row_r_q[2];
  assign row_in_3_i = row_i_q[2];
  assign row_in_4_r = row_r_q[3];
  assign row_in_4_i = row_i_q[3];
  assign row_in_1_f = flag_q[0];
  assign row_in_2_f = flag_q[1];
  assign row_in_3_f = flag_q[2];

  assign m_data_r = m_valid ? rd_r : '0;
  assign m_data_i = m_valid ? rd_i : '0;
  assign m_is_qh  = m_valid & beat_q[BEAT_W-1];
  assign m_last   = m_valid & (beat_q == BEAT_W'(BEATS - 1));
  assign err_wdog = err_wdog_q;
  assign err_miss = err_miss_q;

endmodule
